// File: rtl/pwr_btn_arbiter.sv
// pwr_btn_arbiter: shares the single SIO power-button line between the front
// panel, BMC remote power commands and the power-event logic. One owner at a
// time, press widths timed in 125 ms ticks, enforced release gap after each.
//
// Ports:
//   SysClk              system clock, rising edge
//   InitReset           synchronous active-high reset
//   Strobe125ms         one-cycle tick enable every 125 ms
//   PWR_BTN_IN_N        raw front-panel button, active-low, asynchronous
//   BmcReq / BmcLong    BMC press request (level) and long-press select
//   EvtReq              power-event press request (level, always short)
//   BmcAck / EvtAck     one-cycle grant pulses
//   BmcDone / EvtDone   one-cycle pulses when that owner's press releases
//   FM_SYS_SIO_PWRBTN_N power button to SIO, active-low
//   Busy                arbiter not idle
//   Owner               0 none, 1 front panel, 2 BMC, 3 event
module pwr_btn_arbiter #(
    parameter int unsigned SHORT_TICKS = 4,
    parameter int unsigned LONG_TICKS  = 40,
    parameter int unsigned GAP_TICKS   = 8
) (
    input  logic       SysClk,
    input  logic       InitReset,
    input  logic       Strobe125ms,
    input  logic       PWR_BTN_IN_N,
    input  logic       BmcReq,
    input  logic       BmcLong,
    input  logic       EvtReq,
    output logic       BmcAck,
    output logic       EvtAck,
    output logic       BmcDone,
    output logic       EvtDone,
    output logic       FM_SYS_SIO_PWRBTN_N,
    output logic       Busy,
    output logic [1:0] Owner
);

    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0] C_SHORT = CNT_W'(SHORT_TICKS);
    localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] C_GAP   = CNT_W'(GAP_TICKS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FP_PASS = 2'd1;
    localparam logic [1:0] S_PRESS   = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_FP   = 2'd1;
    localparam logic [1:0] OWN_BMC  = 2'd2;
    localparam logic [1:0] OWN_EVT  = 2'd3;

    logic [1:0]       r_sync;
    logic             r_fp_hist;
    logic             r_fp_press;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_owner;
    logic             r_bmc_ack;
    logic             r_evt_ack;
    logic             r_bmc_done;
    logic             r_evt_done;
    logic             r_pwrbtn_n;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [1:0]       w_owner_nxt;
    logic             w_bmc_ack_nxt;
    logic             w_evt_ack_nxt;
    logic             w_bmc_done_nxt;
    logic             w_evt_done_nxt;
    logic             w_low_nxt;

    // Button synchronizer (every cycle) and tick-sampled debounce.
    // FpPress changes only when two consecutive tick samples agree.
    always_ff @(posedge SysClk) begin
        if (InitReset) begin
            r_sync     <= 2'b11;
            r_fp_hist  <= 1'b1;
            r_fp_press <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], PWR_BTN_IN_N};
            if (Strobe125ms) begin
                r_fp_hist <= r_sync[1];
                if (!r_fp_hist && !r_sync[1]) begin
                    r_fp_press <= 1'b1;
                end else if (r_fp_hist && r_sync[1]) begin
                    r_fp_press <= 1'b0;
                end
            end
        end
    end

    // Next-state, counter, owner and pulse decode; advances only on ticks.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_owner_nxt    = r_owner;
        w_bmc_ack_nxt  = 1'b0;
        w_evt_ack_nxt  = 1'b0;
        w_bmc_done_nxt = 1'b0;
        w_evt_done_nxt = 1'b0;
        if (Strobe125ms) begin
            case (r_state)
                S_IDLE: begin
                    if (r_fp_press) begin
                        w_state_nxt = S_FP_PASS;
                        w_owner_nxt = OWN_FP;
                    end else if (BmcReq) begin
                        w_state_nxt   = S_PRESS;
                        w_owner_nxt   = OWN_BMC;
                        w_count_nxt   = BmcLong ? C_LONG : C_SHORT;
                        w_bmc_ack_nxt = 1'b1;
                    end else if (EvtReq) begin
                        w_state_nxt   = S_PRESS;
                        w_owner_nxt   = OWN_EVT;
                        w_count_nxt   = C_SHORT;
                        w_evt_ack_nxt = 1'b1;
                    end
                end
                S_FP_PASS: begin
                    if (!r_fp_press) begin
                        w_state_nxt = S_GAP;
                        w_count_nxt = C_GAP;
                    end
                end
                S_PRESS: begin
                    if (r_count == CNT_W'(1)) begin
                        w_state_nxt    = S_GAP;
                        w_count_nxt    = C_GAP;
                        w_bmc_done_nxt = (r_owner == OWN_BMC);
                        w_evt_done_nxt = (r_owner == OWN_EVT);
                    end else begin
                        w_count_nxt = r_count - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    // Counter lands on 0 as the gap ends.
                    w_count_nxt = r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_owner_nxt = OWN_NONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_owner_nxt = OWN_NONE;
                    w_count_nxt = '0;
                end
            endcase
        end
        w_low_nxt = (w_state_nxt == S_FP_PASS) || (w_state_nxt == S_PRESS);
    end

    // State and registered outputs.
    always_ff @(posedge SysClk) begin
        if (InitReset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_owner    <= OWN_NONE;
            r_bmc_ack  <= 1'b0;
            r_evt_ack  <= 1'b0;
            r_bmc_done <= 1'b0;
            r_evt_done <= 1'b0;
            r_pwrbtn_n <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_owner    <= w_owner_nxt;
            r_bmc_ack  <= w_bmc_ack_nxt;
            r_evt_ack  <= w_evt_ack_nxt;
            r_bmc_done <= w_bmc_done_nxt;
            r_evt_done <= w_evt_done_nxt;
            r_pwrbtn_n <= !w_low_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign BmcAck              = r_bmc_ack;
    assign EvtAck              = r_evt_ack;
    assign BmcDone             = r_bmc_done;
    assign EvtDone             = r_evt_done;
    assign FM_SYS_SIO_PWRBTN_N = r_pwrbtn_n;
    assign Busy                = r_busy;
    assign Owner               = r_owner;

endmodule

// File: tb/tb_pwr_btn_arbiter.sv
// Directed testbench for pwr_btn_arbiter: a default-parameter instance and a
// minimum-parameter instance (all 1) share the same stimulus.
module tb_pwr_btn_arbiter;

    logic       clk = 1'b0;
    logic       init_reset;
    logic       strobe;
    logic       btn_n;
    logic       bmc_req;
    logic       bmc_long;
    logic       evt_req;

    logic       bmc_ack, evt_ack, bmc_done, evt_done, pwrbtn_n, busy;
    logic [1:0] owner;
    logic       m_bmc_ack, m_evt_ack, m_bmc_done, m_evt_done, m_pwrbtn_n, m_busy;
    logic [1:0] m_owner;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwr_btn_arbiter #(.SHORT_TICKS(4), .LONG_TICKS(40), .GAP_TICKS(8)) u_dut (
        .SysClk(clk), .InitReset(init_reset), .Strobe125ms(strobe),
        .PWR_BTN_IN_N(btn_n), .BmcReq(bmc_req), .BmcLong(bmc_long), .EvtReq(evt_req),
        .BmcAck(bmc_ack), .EvtAck(evt_ack), .BmcDone(bmc_done), .EvtDone(evt_done),
        .FM_SYS_SIO_PWRBTN_N(pwrbtn_n), .Busy(busy), .Owner(owner)
    );

    pwr_btn_arbiter #(.SHORT_TICKS(1), .LONG_TICKS(1), .GAP_TICKS(1)) u_min (
        .SysClk(clk), .InitReset(init_reset), .Strobe125ms(strobe),
        .PWR_BTN_IN_N(btn_n), .BmcReq(bmc_req), .BmcLong(bmc_long), .EvtReq(evt_req),
        .BmcAck(m_bmc_ack), .EvtAck(m_evt_ack), .BmcDone(m_bmc_done), .EvtDone(m_evt_done),
        .FM_SYS_SIO_PWRBTN_N(m_pwrbtn_n), .Busy(m_busy), .Owner(m_owner)
    );

    // One non-tick edge then one tick edge; returns 1 ns after the tick edge.
    task automatic do_tick;
        @(posedge clk); #1 strobe = 1'b1;
        @(posedge clk); #1 strobe = 1'b0;
    endtask

    task automatic apply_reset;
        init_reset = 1'b1;
        strobe     = 1'b0;
        repeat (2) @(posedge clk);
        #1 init_reset = 1'b0;
    endtask

    task automatic test_reset;
        btn_n = 1'b1; bmc_req = 1'b0; bmc_long = 1'b0; evt_req = 1'b0;
        apply_reset();
        n_vec++; if (pwrbtn_n !== 1'b1) begin n_err++; $display("FAIL reset_pwrbtn got %b want 1", pwrbtn_n); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner got %0d want 0", owner); end
        n_vec++; if ({bmc_ack, evt_ack, bmc_done, evt_done} !== 4'b0000) begin
            n_err++; $display("FAIL reset_pulses got %b want 0000", {bmc_ack, evt_ack, bmc_done, evt_done});
        end
    endtask

    task automatic test_bmc_short;
        logic exp;
        bmc_req = 1'b1; bmc_long = 1'b0;
        do_tick();
        n_vec++; if (bmc_ack !== 1'b1) begin n_err++; $display("FAIL short_ack got %b want 1", bmc_ack); end
        n_vec++; if (pwrbtn_n !== 1'b0) begin n_err++; $display("FAIL short_low got %b want 0", pwrbtn_n); end
        n_vec++; if (owner !== 2'd2) begin n_err++; $display("FAIL short_owner got %0d want 2", owner); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL short_busy got %b want 1", busy); end
        bmc_req = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (bmc_ack !== 1'b0) begin n_err++; $display("FAIL short_ack_pulse got %b want 0", bmc_ack); end
        n_vec++; if (pwrbtn_n !== 1'b0) begin n_err++; $display("FAIL short_hold got %b want 0", pwrbtn_n); end
        for (int i = 1; i <= 4; i++) begin
            do_tick();
            exp = (i == 4);
            n_vec++; if (pwrbtn_n !== exp) begin n_err++; $display("FAIL short_width t%0d got %b want %b", i, pwrbtn_n, exp); end
            n_vec++; if (bmc_done !== exp) begin n_err++; $display("FAIL short_done t%0d got %b want %b", i, bmc_done, exp); end
        end
        for (int j = 1; j <= 8; j++) begin
            do_tick();
            exp = (j < 8);
            n_vec++; if (busy !== exp) begin n_err++; $display("FAIL short_gap_busy t%0d got %b want %b", j, busy, exp); end
            n_vec++; if (pwrbtn_n !== 1'b1) begin n_err++; $display("FAIL short_gap_high t%0d got %b want 1", j, pwrbtn_n); end
        end
        n_vec++; if (owner !== 2'd0) begin n_err++; $display("FAIL short_owner_end got %0d want 0", owner); end
    endtask

    task automatic test_bmc_long;
        logic exp;
        bmc_req = 1'b1; bmc_long = 1'b1;
        do_tick();
        n_vec++; if (bmc_ack !== 1'b1) begin n_err++; $display("FAIL long_ack got %b want 1", bmc_ack); end
        bmc_req = 1'b0; bmc_long = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            do_tick();
            exp = (i == 40);
            n_vec++; if (pwrbtn_n !== exp) begin n_err++; $display("FAIL long_width t%0d got %b want %b", i, pwrbtn_n, exp); end
            n_vec++; if (evt_ack !== 1'b0) begin n_err++; $display("FAIL long_no_preempt t%0d got %b want 0", i, evt_ack); end
            if (i == 10) evt_req = 1'b1;
        end
        n_vec++; if (bmc_done !== 1'b1) begin n_err++; $display("FAIL long_done got %b want 1", bmc_done); end
        for (int j = 1; j <= 8; j++) begin
            do_tick();
            exp = (j < 8);
            n_vec++; if (busy !== exp) begin n_err++; $display("FAIL long_gap_busy t%0d got %b want %b", j, busy, exp); end
            n_vec++; if (evt_ack !== 1'b0) begin n_err++; $display("FAIL long_gap_evt t%0d got %b want 0", j, evt_ack); end
        end
        do_tick();
        n_vec++; if (evt_ack !== 1'b1) begin n_err++; $display("FAIL long_evt_ack got %b want 1", evt_ack); end
        n_vec++; if (owner !== 2'd3) begin n_err++; $display("FAIL long_evt_owner got %0d want 3", owner); end
        evt_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            do_tick();
            exp = (i == 4);
            n_vec++; if (pwrbtn_n !== exp) begin n_err++; $display("FAIL long_evt_width t%0d got %b want %b", i, pwrbtn_n, exp); end
        end
        n_vec++; if (evt_done !== 1'b1) begin n_err++; $display("FAIL long_evt_done got %b want 1", evt_done); end
        repeat (8) do_tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL long_idle got %b want 0", busy); end
    endtask

    task automatic test_simultaneous;
        logic exp;
        bmc_req = 1'b1; evt_req = 1'b1; bmc_long = 1'b0;
        do_tick();
        n_vec++; if ({bmc_ack, evt_ack} !== 2'b10) begin n_err++; $display("FAIL sim_grant got %b want 10", {bmc_ack, evt_ack}); end
        n_vec++; if (owner !== 2'd2) begin n_err++; $display("FAIL sim_owner got %0d want 2", owner); end
        bmc_req = 1'b0;
        repeat (4) do_tick();
        n_vec++; if (bmc_done !== 1'b1) begin n_err++; $display("FAIL sim_bmc_done got %b want 1", bmc_done); end
        for (int j = 1; j <= 8; j++) begin
            do_tick();
            n_vec++; if (evt_ack !== 1'b0) begin n_err++; $display("FAIL sim_gap_evt t%0d got %b want 0", j, evt_ack); end
        end
        do_tick();
        n_vec++; if (evt_ack !== 1'b1) begin n_err++; $display("FAIL sim_evt_ack got %b want 1", evt_ack); end
        n_vec++; if (owner !== 2'd3) begin n_err++; $display("FAIL sim_evt_owner got %0d want 3", owner); end
        evt_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            do_tick();
            exp = (i == 4);
            n_vec++; if (pwrbtn_n !== exp) begin n_err++; $display("FAIL sim_evt_width t%0d got %b want %b", i, pwrbtn_n, exp); end
            n_vec++; if (evt_done !== exp) begin n_err++; $display("FAIL sim_evt_done t%0d got %b want %b", i, evt_done, exp); end
        end
        repeat (8) do_tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sim_idle got %b want 0", busy); end
    endtask

    task automatic test_front_panel;
        logic exp;
        // Glitch: low across one tick only, so only one tick sample is low.
        btn_n = 1'b0;
        do_tick();
        btn_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            do_tick();
            n_vec++; if ({pwrbtn_n, busy} !== 2'b10) begin n_err++; $display("FAIL fp_glitch t%0d got %b want 10", i, {pwrbtn_n, busy}); end
        end
        // Real press: sample lag, two low samples, then grant on the next tick.
        btn_n = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            do_tick();
            exp = (i < 4);
            n_vec++; if (pwrbtn_n !== exp) begin n_err++; $display("FAIL fp_latency t%0d got %b want %b", i, pwrbtn_n, exp); end
        end
        n_vec++; if (owner !== 2'd1) begin n_err++; $display("FAIL fp_owner got %0d want 1", owner); end
        n_vec++; if ({bmc_ack, evt_ack} !== 2'b00) begin n_err++; $display("FAIL fp_no_ack got %b want 00", {bmc_ack, evt_ack}); end
        for (int i = 1; i <= 6; i++) begin
            do_tick();
            n_vec++; if (pwrbtn_n !== 1'b0) begin n_err++; $display("FAIL fp_hold t%0d got %b want 0", i, pwrbtn_n); end
        end
        btn_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            do_tick();
            exp = (i == 4);
            n_vec++; if (pwrbtn_n !== exp) begin n_err++; $display("FAIL fp_release t%0d got %b want %b", i, pwrbtn_n, exp); end
        end
        n_vec++; if ({busy, owner} !== 3'b101) begin n_err++; $display("FAIL fp_gap_owner got %b want 101", {busy, owner}); end
        for (int j = 1; j <= 8; j++) begin
            do_tick();
            exp = (j < 8);
            n_vec++; if (busy !== exp) begin n_err++; $display("FAIL fp_gap_busy t%0d got %b want %b", j, busy, exp); end
        end
        n_vec++; if (owner !== 2'd0) begin n_err++; $display("FAIL fp_owner_end got %0d want 0", owner); end
    endtask

    task automatic test_reset_mid_press;
        bmc_req = 1'b1; bmc_long = 1'b1;
        do_tick();
        repeat (19) do_tick();
        n_vec++; if (pwrbtn_n !== 1'b0) begin n_err++; $display("FAIL rst_mid_low got %b want 0", pwrbtn_n); end
        init_reset = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (pwrbtn_n !== 1'b1) begin n_err++; $display("FAIL rst_mid_high got %b want 1", pwrbtn_n); end
        n_vec++; if ({busy, owner} !== 3'b000) begin n_err++; $display("FAIL rst_mid_owner got %b want 000", {busy, owner}); end
        n_vec++; if (bmc_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done got %b want 0", bmc_done); end
        init_reset = 1'b0;
        do_tick();
        n_vec++; if (bmc_ack !== 1'b1) begin n_err++; $display("FAIL rst_regrant got %b want 1", bmc_ack); end
        n_vec++; if (owner !== 2'd2) begin n_err++; $display("FAIL rst_regrant_owner got %0d want 2", owner); end
        bmc_req = 1'b0; bmc_long = 1'b0;
        apply_reset();
    endtask

    task automatic test_min_params;
        bmc_req = 1'b1; bmc_long = 1'b0;
        do_tick();
        n_vec++; if ({m_bmc_ack, m_pwrbtn_n} !== 2'b10) begin n_err++; $display("FAIL min_grant got %b want 10", {m_bmc_ack, m_pwrbtn_n}); end
        do_tick();
        n_vec++; if ({m_pwrbtn_n, m_bmc_done, m_busy} !== 3'b111) begin
            n_err++; $display("FAIL min_release got %b want 111", {m_pwrbtn_n, m_bmc_done, m_busy});
        end
        do_tick();
        n_vec++; if ({m_busy, m_owner, m_bmc_ack} !== 4'b0000) begin
            n_err++; $display("FAIL min_gap_end got %b want 0000", {m_busy, m_owner, m_bmc_ack});
        end
        do_tick();
        n_vec++; if ({m_bmc_ack, m_pwrbtn_n} !== 2'b10) begin n_err++; $display("FAIL min_regrant got %b want 10", {m_bmc_ack, m_pwrbtn_n}); end
        bmc_req = 1'b0;
        repeat (2) do_tick();
        do_tick();
        n_vec++; if ({m_busy, m_pwrbtn_n, m_owner} !== 4'b0100) begin
            n_err++; $display("FAIL min_no_underflow got %b want 0100", {m_busy, m_pwrbtn_n, m_owner});
        end
        apply_reset();
    endtask

    initial begin
        init_reset = 1'b1; strobe = 1'b0; btn_n = 1'b1;
        bmc_req = 1'b0; bmc_long = 1'b0; evt_req = 1'b0;
        test_reset();
        test_bmc_short();
        test_bmc_long();
        test_simultaneous();
        test_front_panel();
        test_reset_mid_press();
        test_min_params();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
